lsu_dmem_ctrl: RTL and testbench
================================

// Module: lsu_dmem_ctrl
// PURPOSE
//  Load/store unit between core datapath and dmem. Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW
//  requests into word-indexed dmem accesses. Uses read-modify-write for sub-word stores (dmem has no
//  byte enables). Sign/zero-extends loads, flags misaligned or illegal accesses. Handles 0- or 1-cycle
//  dmem read latency (synthesized RAM vs BSRAM) with a small FSM and a valid/ready request handshake.
// PARAMETERS
//  MEMORY_TYPE  0   dmem read latency: 0 = combinational (synth RAM), 1 = registered, 1 cycle (BSRAM)
//  ADDR_W       11  dmem word-address width; mem_a[ADDR_W-1:0] = req_addr[ADDR_W+1:2]
// PORTS
//  clk         in   1   single clock; all state on posedge clk
//  reset_n     in   1   asynchronous, active-low reset
//  req_valid   in   1   core request present
//  req_ready   out  1   LSU accepts request (high only in IDLE)
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data (low byte/half used for SB/SH)
//  rsp_valid   out  1   one-cycle pulse: request complete
//  rsp_rdata   out  32  extended load data (0 for stores/errors), held until next rsp
//  rsp_err     out  1   valid with rsp_valid: misaligned or illegal funct3
//  mem_we      out  1   dmem write enable
//  mem_a       out  32  dmem word index, zero-extended from ADDR_W bits
//  mem_wd      out  32  dmem write data
//  mem_rd      in   32  dmem read data
// BEHAVIOUR
//  Reset: state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_a=0, mem_wd=0; req_ready=1.
//  Handshake: accept on posedge where req_valid & req_ready (cycle 0). Latch addr/funct3/we/wdata.
//   req_ready=0 until the cycle after rsp_valid. No response back-pressure: core takes rsp that cycle.
//  Legality checks happen at accept:
//   - H/HU need addr[0]=0; W needs addr[1:0]=0.
//   - Loads: funct3 011/110/111 illegal. Stores: only 000/001/010 legal.
//   - Error -> RESP directly: rsp_err=1, rdata=0, no dmem access. Latency 1.
//  FSM: IDLE -> READ -> (WAIT if MEMORY_TYPE=1) -> WRITE -> RESP -> IDLE; paths by op:
//   LOAD     IDLE->READ[->WAIT]->RESP. mem_rd captured in READ (type 0) or WAIT (type 1).
//   SW       IDLE->WRITE->RESP. mem_we=1 in WRITE, mem_wd=wdata.
//   SB/SH    IDLE->READ[->WAIT]->WRITE->RESP. Merge captured word with new lane, write in WRITE.
//  mem_a is registered at accept and stable from READ through WRITE. Address bits above ADDR_W+1
//   are ignored (wrap modulo 2^(ADDR_W+2)).
//  mem_we=1 only in WRITE, exactly one cycle per store.
//  Latency accept->rsp_valid: load 2/3, SW 2, SB/SH 3/4 cycles (type 0 / type 1); error 1.
//  Load extract: lane = addr[1:0] (byte) or addr[1] (half).
//   - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
//  Store merge:
//   - SB replaces bits [8*addr[1:0] +: 8] with wdata[7:0].
//   - SH replaces [16*addr[1] +: 16] with wdata[15:0].
//   - Other bytes keep the read value.
//  RESP: rsp_valid=1 for exactly one cycle; rsp_rdata/rsp_err hold until next RESP.
//  reset_n low mid-operation: immediate return to IDLE, mem_we drops asynchronously, no rsp issued,
//   the pending request is discarded (store may be lost; never a partially merged word after WRITE).
//  req_valid while busy is ignored; the core must hold the request until accepted.
// STRUCTURE
//  Package lsu_pkg:
//   - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
//   - lsu_state_t enum {IDLE, READ, WAIT, WRITE, RESP}
//   - function is_legal(we, funct3, addr[1:0])
//  Sub-module lsu_align (combinational): load extract/extend and store lane merge, shared by both paths.
//  Top: FSM, request/response registers, dmem port muxing.
// TESTING
//  1. SW 0x12345678 @0x8, then LW @0x8 -> mem_we one cycle at mem_a=2; rdata=0x12345678, err=0.
//  2. Word @0x4 = 0xAABBCCDD; SB 0x11 @0x5 -> dmem word 0xAABB11DD.
//     LB @0x7 -> 0xFFFFFFAA; LBU @0x7 -> 0x000000AA.
//  3. SH 0x8001 @0x6 -> word 0x8001CCDD. LH @0x6 -> 0xFFFF8001; LHU -> 0x00008001.
//  4. LW @0x2, SH @0x3, funct3=011 -> rsp_err=1 after 1 cycle, rdata=0, mem_we never asserted.
//  5. MEMORY_TYPE=1 with 1-cycle registered dmem model: tests 1-3 pass with latencies 3 (LW), 4 (SB).
//  6. Assert reset_n low in WRITE of an SB -> state IDLE, mem_we=0 same cycle, no rsp_valid.
//     Next LW is accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality check applied when a request is accepted.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      WRITE,
      RESP
   } lsu_state_t;

   // Unsigned variants exist only for loads; halves and words must be naturally aligned.
   function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~addr_lo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the LSU: extracts and extends load data from a dmem word and
// merges a byte/half store lane into a previously read word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rword,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_ldata,
   output logic [31:0] o_mdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_rword[7:0];
         2'd1:    w_byte = i_rword[15:8];
         2'd2:    w_byte = i_rword[23:16];
         default: w_byte = i_rword[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

      case (i_funct3)
         F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_ldata = {24'd0, w_byte};
         F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
         F3_HU:   o_ldata = {16'd0, w_half};
         default: o_ldata = i_rword;
      endcase

      // Untouched lanes keep the value just read from dmem.
      o_mdata = i_rword;
      case (i_funct3)
         F3_B: begin
            case (i_addr_lo)
               2'd0:    o_mdata[7:0]   = i_wdata[7:0];
               2'd1:    o_mdata[15:8]  = i_wdata[7:0];
               2'd2:    o_mdata[23:16] = i_wdata[7:0];
               default: o_mdata[31:24] = i_wdata[7:0];
            endcase
         end
         F3_H: begin
            if (i_addr_lo[1])
               o_mdata[31:16] = i_wdata[15:0];
            else
               o_mdata[15:0] = i_wdata[15:0];
         end
         default: o_mdata = i_wdata;
      endcase
   end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit: turns byte-addressed core requests into word-indexed dmem
// accesses, doing read-modify-write for sub-word stores on a byte-enable-less RAM.
module lsu_dmem_ctrl
   import lsu_pkg::*;
#(
   parameter int MEMORY_TYPE = 0,
   parameter int ADDR_W      = 11
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_mem_we,
   output logic [31:0] o_mem_a,
   output logic [31:0] o_mem_wd,
   input  logic [31:0] i_mem_rd
);

   lsu_state_t  r_state;
   lsu_state_t  w_next;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [1:0]  r_addr_lo;
   logic [31:0] r_wdata;
   logic [31:0] r_mem_a;
   logic [31:0] r_mem_wd;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   logic        w_accept;
   logic        w_legal;
   logic        w_capture;
   logic [31:0] w_ldata;
   logic [31:0] w_mdata;
   logic        w_unused;

   assign w_accept  = i_req_valid && (r_state == IDLE);
   assign w_legal   = is_legal(i_req_we, i_req_funct3, i_req_addr[1:0]);
   // Read data is valid in READ for a combinational RAM, one cycle later for BSRAM.
   assign w_capture = (MEMORY_TYPE == 0) ? (r_state == READ) : (r_state == WAIT);
   assign w_unused  = ^{i_req_addr[31:ADDR_W+2]};

   assign o_req_ready = (r_state == IDLE);
   assign o_rsp_valid = (r_state == RESP);
   assign o_mem_we    = (r_state == WRITE);
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;
   assign o_mem_a     = r_mem_a;
   assign o_mem_wd    = r_mem_wd;

   lsu_align u_align (
      .i_funct3  (r_funct3),
      .i_addr_lo (r_addr_lo),
      .i_rword   (i_mem_rd),
      .i_wdata   (r_wdata),
      .o_ldata   (w_ldata),
      .o_mdata   (w_mdata)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (!w_legal)
                  w_next = RESP;
               else if (i_req_we && (i_req_funct3 == F3_W))
                  w_next = WRITE;
               else
                  w_next = READ;
            end
         end
         READ: begin
            if (MEMORY_TYPE == 1)
               w_next = WAIT;
            else if (r_we)
               w_next = WRITE;
            else
               w_next = RESP;
         end
         WAIT:    w_next = r_we ? WRITE : RESP;
         WRITE:   w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_funct3    <= 3'd0;
         r_addr_lo   <= 2'd0;
         r_wdata     <= 32'd0;
         r_mem_a     <= 32'd0;
         r_mem_wd    <= 32'd0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we      <= i_req_we;
            r_funct3  <= i_req_funct3;
            r_addr_lo <= i_req_addr[1:0];
            r_wdata   <= i_req_wdata;
            if (w_legal) begin
               r_mem_a <= {{(32-ADDR_W){1'b0}}, i_req_addr[ADDR_W+1:2]};
               if (i_req_we && (i_req_funct3 == F3_W))
                  r_mem_wd <= i_req_wdata;
            end
         end
         if (w_capture && r_we)
            r_mem_wd <= w_mdata;
         // Response fields change only on entry to RESP so they hold between responses.
         if ((w_next == RESP) && (r_state != RESP)) begin
            r_rsp_err   <= (r_state == IDLE);
            r_rsp_rdata <= (w_capture && !r_we) ? w_ldata : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl: one instance per dmem latency, each with
// its own dmem model, expected responses and expected dmem writes.
module tb_lsu_dmem_ctrl;
   import lsu_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acceptCycle;
      int          lat;
      string       name;
   } expRsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } expWr_t;

   logic        clk = 1'b0;
   int          cycle = 0;
   int          checks = 0;
   int          failures = 0;

   logic        rstN      [2];
   logic        reqValid  [2];
   logic        reqReady  [2];
   logic        rspValid  [2];
   logic [31:0] rspRdata  [2];
   logic        rspErr    [2];
   logic        memWe     [2];
   logic [31:0] memA      [2];
   logic [31:0] memWd     [2];
   logic        reqWe;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic [31:0] memRd0;
   logic [31:0] memRd1;
   logic [31:0] dmem0 [2048];
   logic [31:0] dmem1 [2048];

   expRsp_t rspQ0[$];
   expRsp_t rspQ1[$];
   expWr_t  wrQ0[$];
   expWr_t  wrQ1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   lsu_dmem_ctrl #(.MEMORY_TYPE(0), .ADDR_W(11)) dut0 (
      .i_clk(clk), .i_reset_n(rstN[0]), .i_req_valid(reqValid[0]), .o_req_ready(reqReady[0]),
      .i_req_we(reqWe), .i_req_funct3(reqFunct3), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
      .o_rsp_valid(rspValid[0]), .o_rsp_rdata(rspRdata[0]), .o_rsp_err(rspErr[0]),
      .o_mem_we(memWe[0]), .o_mem_a(memA[0]), .o_mem_wd(memWd[0]), .i_mem_rd(memRd0)
   );

   lsu_dmem_ctrl #(.MEMORY_TYPE(1), .ADDR_W(11)) dut1 (
      .i_clk(clk), .i_reset_n(rstN[1]), .i_req_valid(reqValid[1]), .o_req_ready(reqReady[1]),
      .i_req_we(reqWe), .i_req_funct3(reqFunct3), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
      .o_rsp_valid(rspValid[1]), .o_rsp_rdata(rspRdata[1]), .o_rsp_err(rspErr[1]),
      .o_mem_we(memWe[1]), .o_mem_a(memA[1]), .o_mem_wd(memWd[1]), .i_mem_rd(memRd1)
   );

   // Combinational-read RAM for dut0, registered-read RAM for dut1.
   assign memRd0 = dmem0[memA[0][10:0]];

   always @(posedge clk) begin
      if (memWe[0]) dmem0[memA[0][10:0]] <= memWd[0];
      if (memWe[1]) dmem1[memA[1][10:0]] <= memWd[1];
      memRd1 <= dmem1[memA[1][10:0]];
   end

   task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic expectWrite(input int s, input logic [31:0] addr, input logic [31:0] data);
      expWr_t w;
      w.addr = addr;
      w.data = data;
      if (s == 0) wrQ0.push_back(w); else wrQ1.push_back(w);
   endtask

   task automatic applyStimulus(input int s, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expRdata, input logic expErr,
                                input int lat, input string name);
      expRsp_t e;
      int n;
      @(negedge clk);
      reqWe       = we;
      reqFunct3   = f3;
      reqAddr     = addr;
      reqWdata    = wdata;
      reqValid[s] = 1'b1;
      n = 0;
      while (!reqReady[s] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!reqReady[s]) begin
         checks++;
         failures++;
         $display("[TB] FAIL dut%0d_%s_accept actual=not_ready expected=ready", s, name);
         reqValid[s] = 1'b0;
         return;
      end
      e.rdata       = expRdata;
      e.err         = expErr;
      e.acceptCycle = cycle;
      e.lat         = lat;
      e.name        = name;
      if (s == 0) rspQ0.push_back(e); else rspQ1.push_back(e);
      @(negedge clk);
      reqValid[s] = 1'b0;
   endtask

   task automatic checkOutput(input int s);
      expRsp_t e;
      expWr_t  w;
      int      qs;
      if (rspValid[s]) begin
         qs = (s == 0) ? rspQ0.size() : rspQ1.size();
         if (qs == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL dut%0d_unexpected_rsp actual=rsp_valid rdata=0x%08h expected=none", s, rspRdata[s]);
         end else begin
            if (s == 0) e = rspQ0.pop_front(); else e = rspQ1.pop_front();
            compareVal($sformatf("dut%0d_%s_rdata", s, e.name), rspRdata[s], e.rdata);
            compareVal($sformatf("dut%0d_%s_err", s, e.name), {31'd0, rspErr[s]}, {31'd0, e.err});
            compareVal($sformatf("dut%0d_%s_latency", s, e.name), 32'(cycle - e.acceptCycle), 32'(e.lat));
         end
      end
      if (memWe[s]) begin
         qs = (s == 0) ? wrQ0.size() : wrQ1.size();
         if (qs == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL dut%0d_unexpected_write actual=we@0x%08h expected=none", s, memA[s]);
         end else begin
            if (s == 0) w = wrQ0.pop_front(); else w = wrQ1.pop_front();
            compareVal($sformatf("dut%0d_write_addr", s), memA[s], w.addr);
            compareVal($sformatf("dut%0d_write_data", s), memWd[s], w.data);
         end
      end
   endtask

   always @(negedge clk) checkOutput(0);
   always @(negedge clk) checkOutput(1);

   task automatic runSequence(input int s);
      int ld;
      int sub;
      int n;
      ld  = (s == 0) ? 2 : 3;
      sub = (s == 0) ? 3 : 4;

      expectWrite(s, 32'd2, 32'h12345678);
      applyStimulus(s, 1'b1, F3_W, 32'h8, 32'h12345678, 32'h0, 1'b0, 2, "sw_8");
      applyStimulus(s, 1'b0, F3_W, 32'h8, 32'h0, 32'h12345678, 1'b0, ld, "lw_8");

      expectWrite(s, 32'd1, 32'hAABBCCDD);
      applyStimulus(s, 1'b1, F3_W, 32'h4, 32'hAABBCCDD, 32'h0, 1'b0, 2, "sw_4");
      expectWrite(s, 32'd1, 32'hAABB11DD);
      applyStimulus(s, 1'b1, F3_B, 32'h5, 32'hFFFFFF11, 32'h0, 1'b0, sub, "sb_5");
      applyStimulus(s, 1'b0, F3_W, 32'h4, 32'h0, 32'hAABB11DD, 1'b0, ld, "lw_4_after_sb");
      applyStimulus(s, 1'b0, F3_B, 32'h7, 32'h0, 32'hFFFFFFAA, 1'b0, ld, "lb_7");
      applyStimulus(s, 1'b0, F3_BU, 32'h7, 32'h0, 32'h000000AA, 1'b0, ld, "lbu_7");
      applyStimulus(s, 1'b0, F3_B, 32'h5, 32'h0, 32'h00000011, 1'b0, ld, "lb_5");
      applyStimulus(s, 1'b0, F3_B, 32'h4, 32'h0, 32'hFFFFFFDD, 1'b0, ld, "lb_4");

      expectWrite(s, 32'd1, 32'hAABBCCDD);
      applyStimulus(s, 1'b1, F3_W, 32'h4, 32'hAABBCCDD, 32'h0, 1'b0, 2, "sw_4_again");
      expectWrite(s, 32'd1, 32'h8001CCDD);
      applyStimulus(s, 1'b1, F3_H, 32'h6, 32'h12348001, 32'h0, 1'b0, sub, "sh_6");
      applyStimulus(s, 1'b0, F3_H, 32'h6, 32'h0, 32'hFFFF8001, 1'b0, ld, "lh_6");
      applyStimulus(s, 1'b0, F3_HU, 32'h6, 32'h0, 32'h00008001, 1'b0, ld, "lhu_6");
      applyStimulus(s, 1'b0, F3_H, 32'h4, 32'h0, 32'hFFFFCCDD, 1'b0, ld, "lh_4");
      applyStimulus(s, 1'b0, F3_W, 32'h4, 32'h0, 32'h8001CCDD, 1'b0, ld, "lw_4_after_sh");

      expectWrite(s, 32'd0, 32'h00007FFF);
      applyStimulus(s, 1'b1, F3_H, 32'h0, 32'hFFFF7FFF, 32'h0, 1'b0, sub, "sh_0");
      applyStimulus(s, 1'b0, F3_H, 32'h0, 32'h0, 32'h00007FFF, 1'b0, ld, "lh_0");

      applyStimulus(s, 1'b0, F3_W, 32'h2, 32'h0, 32'h0, 1'b1, 1, "err_lw_2");
      applyStimulus(s, 1'b1, F3_H, 32'h3, 32'h5555, 32'h0, 1'b1, 1, "err_sh_3");
      applyStimulus(s, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, "err_ld_f3_011");
      applyStimulus(s, 1'b1, F3_BU, 32'h0, 32'h77, 32'h0, 1'b1, 1, "err_st_f3_100");
      applyStimulus(s, 1'b0, F3_H, 32'h1, 32'h0, 32'h0, 1'b1, 1, "err_lh_1");

      applyStimulus(s, 1'b0, F3_W, 32'h2008, 32'h0, 32'h12345678, 1'b0, ld, "lw_wrap");

      // Reset during the WRITE of an SB: the store must vanish without a response.
      @(negedge clk);
      reqWe       = 1'b1;
      reqFunct3   = F3_B;
      reqAddr     = 32'h4;
      reqWdata    = 32'h55;
      reqValid[s] = 1'b1;
      n = 0;
      while (!reqReady[s] && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      reqValid[s] = 1'b0;
      n = 0;
      while (!memWe[s] && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      compareVal($sformatf("dut%0d_rst_reached_write", s), {31'd0, memWe[s]}, 32'd1);
      rstN[s] = 1'b0;
      #1;
      compareVal($sformatf("dut%0d_rst_mem_we", s), {31'd0, memWe[s]}, 32'd0);
      compareVal($sformatf("dut%0d_rst_req_ready", s), {31'd0, reqReady[s]}, 32'd1);
      compareVal($sformatf("dut%0d_rst_rsp_valid", s), {31'd0, rspValid[s]}, 32'd0);
      @(negedge clk);
      rstN[s] = 1'b1;

      applyStimulus(s, 1'b0, F3_W, 32'h4, 32'h0, 32'h8001CCDD, 1'b0, ld, "lw_after_rst");
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 2048; i++) begin
         dmem0[i] = 32'd0;
         dmem1[i] = 32'd0;
      end
      rstN[0]     = 1'b0;
      rstN[1]     = 1'b0;
      reqValid[0] = 1'b0;
      reqValid[1] = 1'b0;
      reqWe       = 1'b0;
      reqFunct3   = 3'd0;
      reqAddr     = 32'd0;
      reqWdata    = 32'd0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         compareVal($sformatf("dut%0d_reset_req_ready", s), {31'd0, reqReady[s]}, 32'd1);
         compareVal($sformatf("dut%0d_reset_rsp_valid", s), {31'd0, rspValid[s]}, 32'd0);
         compareVal($sformatf("dut%0d_reset_rsp_err", s), {31'd0, rspErr[s]}, 32'd0);
         compareVal($sformatf("dut%0d_reset_rsp_rdata", s), rspRdata[s], 32'd0);
         compareVal($sformatf("dut%0d_reset_mem_we", s), {31'd0, memWe[s]}, 32'd0);
         compareVal($sformatf("dut%0d_reset_mem_a", s), memA[s], 32'd0);
         compareVal($sformatf("dut%0d_reset_mem_wd", s), memWd[s], 32'd0);
      end
      rstN[0] = 1'b1;
      rstN[1] = 1'b1;

      runSequence(0);
      runSequence(1);

      repeat (10) @(negedge clk);
      compareVal("pending_rsp_dut0", 32'(rspQ0.size()), 32'd0);
      compareVal("pending_rsp_dut1", 32'(rspQ1.size()), 32'd0);
      compareVal("pending_wr_dut0", 32'(wrQ0.size()), 32'd0);
      compareVal("pending_wr_dut1", 32'(wrQ1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
